// File: rtl/pifo_deq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pifo_deq_ctrl_pkg
//  Description : Shared encodings and default field widths for the PIFO
//                dequeue stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package pifo_deq_ctrl_pkg;

    // Field widths shared with the pifo register
    localparam int C_RANK_WIDTH = 16;
    localparam int C_META_WIDTH = 12;

    // Dequeue FSM encodings
    typedef enum logic [1:0] {
        DEQ_IDLE = 2'd0,
        DEQ_POP  = 2'd1,
        DEQ_HOLD = 2'd2
    } deq_state_e;

endpackage : pifo_deq_ctrl_pkg
`default_nettype wire

// File: rtl/pifo_deq_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pifo_deq_fifo
//  Description : Small synchronous first-word-fall-through FIFO. The head
//                entry is always visible on rd_data; level reports occupancy.
//  Revision    : 1.0 - initial release
// ============================================================================
module pifo_deq_fifo #(
    parameter int WIDTH    = 28,
    parameter int L2_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                rd_en,
    output logic [WIDTH-1:0]    rd_data,
    output logic [L2_DEPTH:0]   level
);

    localparam int C_DEPTH = 2 ** L2_DEPTH;

    logic [WIDTH-1:0]    r_mem [C_DEPTH];
    logic [L2_DEPTH-1:0] r_wr_ptr;
    logic [L2_DEPTH-1:0] r_rd_ptr;
    logic [L2_DEPTH:0]   r_level;

    // Storage array; contents need no reset since level gates visibility
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap modulo depth; level tracks occupancy, unchanged on write+read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (wr_en) begin
                r_wr_ptr <= r_wr_ptr + L2_DEPTH'(1);
            end
            if (rd_en) begin
                r_rd_ptr <= r_rd_ptr + L2_DEPTH'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   r_level <= r_level + (L2_DEPTH+1)'(1);
                2'b01:   r_level <= r_level - (L2_DEPTH+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign level   = r_level;

endmodule : pifo_deq_fifo
`default_nettype wire

// File: rtl/pifo_deq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pifo_deq_ctrl
//  Description : Dequeue stage behind the pifo register. Pops the min-rank
//                entry into a prefetch FIFO (one pop per IDLE/POP/HOLD
//                sequence) and presents it on a valid/ready stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module pifo_deq_ctrl
    import pifo_deq_ctrl_pkg::*;
#(
    parameter int RANK_WIDTH    = C_RANK_WIDTH,
    parameter int META_WIDTH    = C_META_WIDTH,
    parameter int L2_FIFO_DEPTH = 2,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pause,
    input  logic                     pifo_valid_in,
    input  logic [RANK_WIDTH-1:0]    pifo_rank_in,
    input  logic [META_WIDTH-1:0]    pifo_meta_in,
    output logic                     pifo_remove,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [RANK_WIDTH-1:0]    m_rank,
    output logic [META_WIDTH-1:0]    m_meta,
    output logic [L2_FIFO_DEPTH:0]   fifo_level,
    output logic [CNT_WIDTH-1:0]     pop_count
);

    localparam int                   C_ENTRY_WIDTH = RANK_WIDTH + META_WIDTH;
    localparam logic [L2_FIFO_DEPTH:0] C_DEPTH_LVL = (L2_FIFO_DEPTH+1)'(2 ** L2_FIFO_DEPTH);

    deq_state_e                 r_state;
    deq_state_e                 w_state_nxt;
    logic                       w_not_full;
    logic                       w_rd_en;
    logic [C_ENTRY_WIDTH-1:0]   w_rd_data;
    logic [CNT_WIDTH-1:0]       r_pop_count;

    // Full check uses the registered level only; a same-cycle read is ignored
    assign w_not_full = (fifo_level < C_DEPTH_LVL);

    // FSM state register; reset aborts any pop in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DEQ_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and remove strobe; remove is decoded from state so reset clears it at once
    always_comb begin
        w_state_nxt = r_state;
        pifo_remove = 1'b0;
        case (r_state)
            DEQ_IDLE: begin
                // pause is only honoured here so a committed pop is never cancelled
                if (pifo_valid_in && !pause && w_not_full) begin
                    w_state_nxt = DEQ_POP;
                end
            end
            DEQ_POP: begin
                // valid may drop (concurrent insert); then nothing is taken
                pifo_remove = pifo_valid_in & w_not_full;
                w_state_nxt = (pifo_valid_in && w_not_full) ? DEQ_HOLD : DEQ_IDLE;
            end
            DEQ_HOLD: begin
                // register valid is stale for one cycle after a remove
                w_state_nxt = DEQ_IDLE;
            end
            default: begin
                w_state_nxt = DEQ_IDLE;
            end
        endcase
    end

    // Count every entry removed from the pifo register; wraps silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pop_count <= '0;
        end else if (pifo_remove) begin
            r_pop_count <= r_pop_count + CNT_WIDTH'(1);
        end
    end

    assign pop_count = r_pop_count;
    assign m_valid   = (fifo_level != '0);
    assign w_rd_en   = m_valid & m_ready;

    pifo_deq_fifo #(
        .WIDTH    (C_ENTRY_WIDTH),
        .L2_DEPTH (L2_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (pifo_remove),
        .wr_data ({pifo_rank_in, pifo_meta_in}),
        .rd_en   (w_rd_en),
        .rd_data (w_rd_data),
        .level   (fifo_level)
    );

    assign m_rank = w_rd_data[C_ENTRY_WIDTH-1:META_WIDTH];
    assign m_meta = w_rd_data[META_WIDTH-1:0];

endmodule : pifo_deq_ctrl
`default_nettype wire

// File: tb/tb_pifo_deq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pifo_deq_ctrl
//  Description : Self-checking bench for pifo_deq_ctrl. A behavioural pifo
//                register model feeds the DUT; removed entries go to a
//                scoreboard queue and are compared as they leave on m_*.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pifo_deq_ctrl;

    localparam int RW = 16;
    localparam int MW = 12;
    localparam int L2 = 2;
    localparam int CW = 4;

    typedef struct packed {
        logic [RW-1:0] rank;
        logic [MW-1:0] meta;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pause;
    logic          pifo_valid_in;
    logic [RW-1:0] pifo_rank_in;
    logic [MW-1:0] pifo_meta_in;
    logic          pifo_remove;
    logic          m_valid;
    logic          m_ready;
    logic [RW-1:0] m_rank;
    logic [MW-1:0] m_meta;
    logic [L2:0]   fifo_level;
    logic [CW-1:0] pop_count;

    ent_t        model_q[$];
    ent_t        sb_q[$];
    ent_t        out_q[$];
    int          rm_cyc[$];
    int          errors = 0;
    int          checks = 0;
    int          rm_cnt = 0;
    int          cyc = 0;
    int unsigned exp_cnt = 0;
    int unsigned meta_ctr = 1;
    logic        stale = 1'b0;
    logic        force_invalid = 1'b0;

    pifo_deq_ctrl #(
        .RANK_WIDTH    (RW),
        .META_WIDTH    (MW),
        .L2_FIFO_DEPTH (L2),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pause         (pause),
        .pifo_valid_in (pifo_valid_in),
        .pifo_rank_in  (pifo_rank_in),
        .pifo_meta_in  (pifo_meta_in),
        .pifo_remove   (pifo_remove),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_rank        (m_rank),
        .m_meta        (m_meta),
        .fifo_level    (fifo_level),
        .pop_count     (pop_count)
    );

    always #5 clk = ~clk;

    // Single comparison point
    task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int min_idx();
        int m;
        m = 0;
        for (int i = 1; i < model_q.size(); i++) begin
            if (model_q[i].rank < model_q[m].rank) m = i;
        end
        return m;
    endfunction

    task automatic add_entry(input int unsigned r);
        ent_t e;
        e.rank = RW'(r);
        e.meta = MW'(meta_ctr);
        meta_ctr++;
        model_q.push_back(e);
    endtask

    // Present the model's min entry; valid is low for one cycle after a remove
    task automatic drive();
        if (model_q.size() != 0 && !stale && !force_invalid) begin
            int k;
            k = min_idx();
            pifo_valid_in = 1'b1;
            pifo_rank_in  = model_q[k].rank;
            pifo_meta_in  = model_q[k].meta;
        end else begin
            pifo_valid_in = 1'b0;
            pifo_rank_in  = '0;
            pifo_meta_in  = '0;
        end
    endtask

    // One clock: sample at negedge, update model and inputs just after posedge
    task automatic step();
        logic s_rm;
        logic s_fire;
        ent_t got;
        ent_t e;
        @(negedge clk);
        s_rm   = pifo_remove;
        s_fire = m_valid & m_ready;
        got.rank = m_rank;
        got.meta = m_meta;
        if (s_fire) begin
            out_q.push_back(got);
            if (sb_q.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("m_rank", 32'(got.rank), 32'(e.rank));
                chk("m_meta", 32'(got.meta), 32'(e.meta));
            end
        end
        if (s_rm) begin
            if (model_q.size() == 0) begin
                chk("remove_when_empty", 1, 0);
            end else begin
                int k;
                k = min_idx();
                sb_q.push_back(model_q[k]);
                model_q.delete(k);
            end
            rm_cnt++;
            rm_cyc.push_back(cyc);
            exp_cnt = (exp_cnt + 1) % (1 << CW);
        end
        @(posedge clk);
        #1;
        cyc++;
        stale = s_rm;
        if (s_rm) chk("pop_count", 32'(pop_count), exp_cnt);
        drive();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        m_ready = 1'b1;
        while ((model_q.size() != 0 || sb_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        if (model_q.size() != 0 || sb_q.size() != 0) chk("drain_timeout", 1, 0);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        pause = 1'b0;
        m_ready = 1'b0;
        stale = 1'b0;
        force_invalid = 1'b0;
        model_q.delete();
        sb_q.delete();
        out_q.delete();
        rm_cyc.delete();
        rm_cnt = 0;
        exp_cnt = 0;
        drive();
        #1;
        chk("rst_remove", 32'(pifo_remove), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_pop_count", 32'(pop_count), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        pause = 1'b0;
        m_ready = 1'b0;
        pifo_valid_in = 1'b0;
        pifo_rank_in = '0;
        pifo_meta_in = '0;

        // 1: ranks {5,2,9} drain in rank order, removes 3 cycles apart
        reset_dut();
        add_entry(5); add_entry(2); add_entry(9);
        m_ready = 1'b1;
        drive();
        drain(60);
        chk("t1_pop_count", 32'(pop_count), 3);
        chk("t1_out_n", out_q.size(), 3);
        if (out_q.size() == 3) begin
            chk("t1_rank0", 32'(out_q[0].rank), 2);
            chk("t1_rank1", 32'(out_q[1].rank), 5);
            chk("t1_rank2", 32'(out_q[2].rank), 9);
        end
        if (rm_cyc.size() == 3) begin
            chk("t1_space01", rm_cyc[1] - rm_cyc[0], 3);
            chk("t1_space12", rm_cyc[2] - rm_cyc[1], 3);
        end else begin
            chk("t1_rm_n", rm_cyc.size(), 3);
        end

        // 2: backpressure fills the FIFO to DEPTH, then drains and resumes
        reset_dut();
        for (int i = 0; i < 6; i++) add_entry(15 - i);
        drive();
        repeat (30) step();
        chk("t2_removes_full", rm_cnt, 4);
        chk("t2_level_full", 32'(fifo_level), 4);
        chk("t2_m_valid", 32'(m_valid), 1);
        drain(200);
        chk("t2_removes_total", rm_cnt, 6);
        chk("t2_out_n", out_q.size(), 6);

        // 3: pause holds off pops while in IDLE
        reset_dut();
        add_entry(7);
        pause = 1'b1;
        m_ready = 1'b1;
        drive();
        repeat (20) step();
        chk("t3_paused", rm_cnt, 0);
        pause = 1'b0;
        step();
        chk("t3_rm_early", rm_cnt, 0);
        step();
        chk("t3_rm_next", rm_cnt, 1);
        drain(20);

        // 4: valid dropping in the POP cycle cancels the pop
        reset_dut();
        add_entry(3);
        drive();
        force_invalid = 1'b1;
        step();
        step();
        chk("t4_no_remove", rm_cnt, 0);
        chk("t4_level", 32'(fifo_level), 0);
        chk("t4_pop_count", 32'(pop_count), 0);
        force_invalid = 1'b0;
        drive();
        drain(20);
        chk("t4_later_pop", rm_cnt, 1);

        // 5: reset asserted during POP clears remove and all state immediately
        reset_dut();
        add_entry(1); add_entry(4);
        drive();
        for (int i = 0; i < 20; i++) begin
            step();
            if (rm_cnt == 1 && pifo_remove) break;
        end
        chk("t5_in_pop", 32'(pifo_remove), 1);
        chk("t5_level_pre", 32'(fifo_level), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_remove_async", 32'(pifo_remove), 0);
        chk("t5_level", 32'(fifo_level), 0);
        chk("t5_m_valid", 32'(m_valid), 0);
        chk("t5_pop_count", 32'(pop_count), 0);

        // 6a: 16 pops with a 4-bit counter wrap it back to 0
        reset_dut();
        for (int i = 0; i < 16; i++) add_entry($urandom_range(0, 1000));
        m_ready = 1'b1;
        drive();
        drain(400);
        chk("t6_removes", rm_cnt, 16);
        chk("t6_wrap", 32'(pop_count), 0);

        // 6b: write and read together at level 2 keep level and order
        reset_dut();
        add_entry(30); add_entry(20); add_entry(40);
        drive();
        for (int i = 0; i < 40; i++) begin
            step();
            if (rm_cnt == 2 && pifo_remove) break;
        end
        chk("t6_simul_pre", 32'(fifo_level), 2);
        chk("t6_simul_rm", 32'(pifo_remove), 1);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("t6_simul_level", 32'(fifo_level), 2);
        drain(40);
        chk("t6_out_n", out_q.size(), 3);
        if (out_q.size() == 3) begin
            chk("t6_ord0", 32'(out_q[0].rank), 20);
            chk("t6_ord1", 32'(out_q[1].rank), 30);
            chk("t6_ord2", 32'(out_q[2].rank), 40);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pifo_deq_ctrl
`default_nettype wire
